// File: rtl/fp32_normalize_pack_if.sv
// ---------------------------------------------------------------------------
// fp32_normalize_pack_if
// Bundles the two handshakes of the normalize/pack back end.
//   in_*  : raw adder result offered by the producer (valid/ready)
//   out_* : packed IEEE-754 word plus flags offered to the consumer
// Handshake rule, both sides: a word moves on a rising clock edge where
// valid and ready are both high. The sender holds its payload stable while
// valid is high and ready is low. Ready may be high without valid.
// Modports:
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : the block itself (drives in_ready, out_*)
// ---------------------------------------------------------------------------
interface fp32_normalize_pack_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int GRS_W  = 3
);
    localparam int MANT_W = 2 + FRAC_W + GRS_W;
    localparam int DATA_W = 1 + EXP_W + FRAC_W;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;
    logic              out_zero;
    logic              out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_zero, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_zero, out_inexact
    );
endinterface

// File: rtl/fp32_normalize_pack.sv
// ---------------------------------------------------------------------------
// fp32_normalize_pack
// Back end of the FP add datapath. Takes a raw adder result (sign, biased
// exponent, unnormalized magnitude with carry/hidden/fraction/GRS), shifts it
// into normal form one bit per cycle, rounds to nearest-even and packs it
// into an IEEE-754 word with overflow/zero/inexact flags.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : fp32_normalize_pack_if.slave (in_* and out_* handshakes)
//   o_dbg_state  : current FSM state (IDLE=0, NORM=1, ROUND=2, DONE=3)
// No denormals or NaNs: underflow flushes to signed zero, overflow
// saturates to signed Inf.
// ---------------------------------------------------------------------------
module fp32_normalize_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int GRS_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fp32_normalize_pack_if.slave      bus,
    output logic [1:0]                o_dbg_state
);
    localparam int MANT_W = 2 + FRAC_W + GRS_W;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int XE_W   = EXP_W + 2;
    localparam int DATA_W = 1 + EXP_W + FRAC_W;
    localparam logic [XE_W-1:0] EXP_MAX = XE_W'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_sign;
    logic [XE_W-1:0]     r_exp;
    logic [MANT_W-1:0]   r_mant;
    logic                r_inf_in;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_ovf;
    logic                r_zero;
    logic                r_inexact;

    logic                w_mant_zero;
    logic                w_carry;
    logic                w_hidden;
    logic                w_exp_low;
    logic [SIG_W-1:0]    w_sig;
    logic [GRS_W-1:0]    w_grs;
    logic                w_round_up;
    logic [SIG_W:0]      w_sum;
    logic [SIG_W-1:0]    w_rnd_sig;
    logic [XE_W-1:0]     w_rnd_exp;
    logic                w_rnd_ovf;

    assign w_mant_zero = (r_mant == '0);
    assign w_carry     = r_mant[MANT_W-1];
    assign w_hidden    = r_mant[MANT_W-2];
    assign w_exp_low   = (r_exp <= XE_W'(1));

    // Rounding: the significand is {hidden, frac}; GRS sit below it.
    assign w_sig      = r_mant[MANT_W-2 -: SIG_W];
    assign w_grs      = r_mant[GRS_W-1:0];
    assign w_round_up = w_grs[GRS_W-1] & ((|w_grs[GRS_W-2:0]) | w_sig[0]);
    assign w_sum      = {1'b0, w_sig} + (SIG_W+1)'(w_round_up);
    // A carry out of the increment means the significand became 10.000...;
    // renormalizing by one right shift only ever drops a zero bit.
    assign w_rnd_sig  = w_sum[SIG_W] ? w_sum[SIG_W:1] : w_sum[SIG_W-1:0];
    assign w_rnd_exp  = r_exp + XE_W'(w_sum[SIG_W]);
    assign w_rnd_ovf  = (w_rnd_exp >= EXP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_NORM;
            S_NORM: begin
                if (w_mant_zero || r_inf_in)   w_next = S_DONE;
                else if (w_carry)              w_next = S_ROUND;
                else if (!w_hidden && w_exp_low) w_next = S_DONE;
                else if (!w_hidden)            w_next = S_NORM;
                else                           w_next = S_ROUND;
            end
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            r_inf_in   <= 1'b0;
            r_out_data <= '0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_inexact  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign   <= bus.in_sign;
                        r_exp    <= {2'b00, bus.in_exp};
                        r_mant   <= bus.in_mant;
                        r_inf_in <= &bus.in_exp;
                    end
                end
                S_NORM: begin
                    if (w_mant_zero) begin
                        // Exact cancellation always yields +0.
                        r_out_data <= '0;
                        r_ovf      <= 1'b0;
                        r_zero     <= 1'b1;
                        r_inexact  <= 1'b0;
                    end else if (r_inf_in) begin
                        r_out_data <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        r_ovf      <= 1'b1;
                        r_zero     <= 1'b0;
                        r_inexact  <= 1'b0;
                    end else if (w_carry) begin
                        // Bit shifted out of R position folds into sticky.
                        r_mant <= {1'b0, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + XE_W'(1);
                    end else if (!w_hidden && w_exp_low) begin
                        r_out_data <= {r_sign, {(DATA_W-1){1'b0}}};
                        r_ovf      <= 1'b0;
                        r_zero     <= 1'b1;
                        r_inexact  <= 1'b1;
                    end else if (!w_hidden) begin
                        r_mant <= {r_mant[MANT_W-2:0], 1'b0};
                        r_exp  <= r_exp - XE_W'(1);
                    end
                end
                S_ROUND: begin
                    r_inexact <= |w_grs;
                    r_zero    <= 1'b0;
                    if (w_rnd_ovf) begin
                        r_out_data <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        r_ovf      <= 1'b1;
                    end else begin
                        r_out_data <= {r_sign, w_rnd_exp[EXP_W-1:0], w_rnd_sig[FRAC_W-1:0]};
                        r_ovf      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.out_data    = r_out_data;
    assign bus.out_ovf     = r_ovf;
    assign bus.out_zero    = r_zero;
    assign bus.out_inexact = r_inexact;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_fp32_normalize_pack.sv
module tb_fp32_normalize_pack;
    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    fp32_normalize_pack_if bus ();

    fp32_normalize_pack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Works on the numeric value: magnitude m scaled by 2^(e - bias - 26).
    function automatic void model(input bit s, input int e, input longint m,
                                  output logic [31:0] d, output bit ovf,
                                  output bit zero, output bit inx, output int lat);
        longint q;
        longint rem;
        int     k;
        ovf = 0; zero = 0; inx = 0; d = 32'h0; lat = 1;
        if (m == 0) begin
            zero = 1; lat = 1; return;
        end
        if (e == 255) begin
            ovf = 1; d = {s, 8'hFF, 23'h0}; lat = 1; return;
        end
        if (m >= (64'd1 << 27)) begin
            m = (m / 2) | (m % 2);
            e = e + 1;
            lat = 2;
        end else begin
            k = 0;
            while (m < (64'd1 << 26)) begin
                if (e <= 1) begin
                    zero = 1; inx = 1; d = {s, 31'h0}; lat = k + 1; return;
                end
                m = m * 2; e = e - 1; k++;
            end
            lat = 2 + k;
        end
        q   = m / 8;
        rem = m % 8;
        inx = (rem != 0);
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q / 2; e = e + 1;
        end
        if (e >= 255) begin
            ovf = 1; d = {s, 8'hFF, 23'h0};
        end else begin
            d = {s, 8'(e), 23'(q - (64'd1 << 23))};
        end
    endfunction

    // ---------------- driver ----------------
    // Offers one word, measures edges from accept to out_valid, captures the
    // result and then accepts it with a one-cycle out_ready pulse.
    task automatic apply(input bit s, input logic [7:0] e, input logic [27:0] m,
                         output logic [31:0] d, output bit ovf, output bit zero,
                         output bit inx, output int lat, output bit to);
        int n;
        to = 0; lat = 0; n = 0;
        d = 32'h0; ovf = 0; zero = 0; inx = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            if (n >= 100) begin to = 1; return; end
            @(negedge clk); n++;
        end
        bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = e; bus.in_mant = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid) begin
            if (lat >= 64) begin to = 1; return; end
            @(posedge clk); #1; lat++;
        end
        d = bus.out_data; ovf = bus.out_ovf; zero = bus.out_zero; inx = bus.out_inexact;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.in_valid = 0; bus.in_sign = 0; bus.in_exp = 0; bus.in_mant = 0; bus.out_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_vec++; if ({bus.out_ovf, bus.out_zero, bus.out_inexact} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.out_ovf, bus.out_zero, bus.out_inexact}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        bit          s_t [12] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic [7:0]  e_t [12] = '{8'h80, 8'h82, 8'h7F, 8'h7F, 8'hFE, 8'h55, 8'hFF, 8'h01, 8'h40, 8'h7F, 8'h80, 8'h80};
        logic [27:0] m_t [12] = '{28'h6000000, 28'h3800000, 28'hC000000, 28'h7FFFFFC, 28'h8000000, 28'h0,
                                  28'h6000000, 28'h1000000, 28'h0, 28'h0000008, 28'h4000004, 28'h400000C};
        logic [31:0] d_t [12] = '{32'h40400000, 32'hC0E00000, 32'h40400000, 32'h40000000, 32'h7F800000, 32'h0,
                                  32'hFF800000, 32'h80000000, 32'h0, 32'h34000000, 32'h40000000, 32'h40000002};
        logic [2:0]  f_t [12] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b010,
                                  3'b100, 3'b011, 3'b010, 3'b000, 3'b001, 3'b001};
        int          l_t [12] = '{2, 3, 2, 2, 2, 1, 1, 1, 1, 25, 2, 2};
        logic [31:0] d;
        bit ovf, zero, inx, to;
        int lat;
        for (int i = 0; i < 12; i++) begin
            apply(s_t[i], e_t[i], m_t[i], d, ovf, zero, inx, lat, to);
            n_vec++;
            if (to) begin n_fail++; $display("FAIL dir%0d_timeout: no result within bound", i); continue; end
            if (d !== d_t[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, d, d_t[i]); end
            n_vec++;
            if ({ovf, zero, inx} !== f_t[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b want %b", i, {ovf, zero, inx}, f_t[i]); end
            n_vec++;
            if (lat != l_t[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, l_t[i]); end
        end
    endtask

    task automatic test_random();
        bit          s;
        logic [7:0]  e;
        logic [27:0] m;
        int          pos, cat, lat, elat;
        logic [31:0] d, ed, qd;
        bit ovf, zero, inx, to, eovf, ezero, einx;
        for (int i = 0; i < 300; i++) begin
            cat = $urandom_range(0, 9);
            s   = 1'($urandom_range(0, 1));
            e   = 8'($urandom_range(2, 253));
            pos = ($urandom_range(0, 1) == 1) ? $urandom_range(26, 27) : $urandom_range(0, 27);
            m   = (28'($urandom) & ((28'd1 << pos) - 28'd1)) | (28'd1 << pos);
            case (cat)
                0: m = 28'h0;
                1: e = 8'hFF;
                2: begin e = 8'($urandom_range(250, 254)); m[27] = 1'($urandom_range(0, 1)); m[26] = 1'b1; end
                3: e = 8'($urandom_range(0, 4));
                default: ;
            endcase
            model(s, int'(e), longint'(m), ed, eovf, ezero, einx, elat);
            exp_q.push_back(ed);
            apply(s, e, m, d, ovf, zero, inx, lat, to);
            qd = exp_q.pop_front();
            n_vec++;
            if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: s=%b e=%h m=%h", i, s, e, m); continue; end
            if (d !== qd) begin n_fail++; $display("FAIL rnd%0d_data: s=%b e=%h m=%h got %h want %h", i, s, e, m, d, qd); end
            n_vec++;
            if ({ovf, zero, inx} !== {eovf, ezero, einx}) begin
                n_fail++; $display("FAIL rnd%0d_flags: s=%b e=%h m=%h got %b want %b", i, s, e, m, {ovf, zero, inx}, {eovf, ezero, einx}); end
            n_vec++;
            if (lat != elat) begin n_fail++; $display("FAIL rnd%0d_latency: e=%h m=%h got %0d want %0d", i, e, m, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exp = 8'h80; bus.in_mant = 28'h6000000;
        @(posedge clk); #1;
        // Keep offering a different word while busy; it must be ignored.
        bus.in_sign = 1'b1; bus.in_exp = 8'h82; bus.in_mant = 28'h3800000;
        while (!bus.out_valid && n < 64) begin @(posedge clk); #1; n++; end
        n_vec++;
        if (!bus.out_valid) begin n_fail++; $display("FAIL bp_timeout: out_valid never rose"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++; if (bus.out_data !== 32'h40400000) begin n_fail++; $display("FAIL bp_data%0d: got %h want 40400000", i, bus.out_data); end
            n_vec++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", i, bus.out_valid); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, bus.in_ready); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
        // in_valid was high on the release edge: it must not have been taken.
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_reaccept: in_ready got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [31:0] d;
        bit ovf, zero, inx, to;
        int lat;
        seen = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exp = 8'h7F; bus.in_mant = 28'h0000008;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_busy: in_ready got %b want 0", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready_async: got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_discard: out_valid rose after reset, got %b want 0", seen); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b want 1", bus.in_ready); end
        apply(1'b0, 8'h80, 28'h6000000, d, ovf, zero, inx, lat, to);
        n_vec++;
        if (to || d !== 32'h40400000) begin n_fail++; $display("FAIL rm_recover: got %h (timeout=%b) want 40400000", d, to); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
